extbus_master_6502: RTL

- 6502-style bus initiator: turns single-beat internal requests into PHY2-timed bus cycles (cs_n, rw_n, a[2:0], d[7:0]) toward a 6502-slave peripheral.
- Honours the open-drain RDY wait line and synchronises the open-drain IRQ line.
- Used as the on-chip host for bring-up, self-test and loopback of the 6502 slave register interface.
- Data bus is split into in/out/oe; the top level owns the tristate pad.

---
 rtl/extbus_pkg.sv | 25 ++
 rtl/extbus_master_6502_sync2.sv | 24 ++
 rtl/extbus_master_6502.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/extbus_pkg.sv
// Shared definitions for the 6502-style external bus master: FSM encoding,
// slave register map and default PHY2 timing.
package extbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_LOW   = 2'd2,
        ST_HIGH  = 2'd3
    } bm_state_e;

    localparam logic [2:0] REG_ADDRx_H = 3'd0;
    localparam logic [2:0] REG_ADDRx_M = 3'd1;
    localparam logic [2:0] REG_ADDRx_L = 3'd2;
    localparam logic [2:0] REG_DATA0   = 3'd3;
    localparam logic [2:0] REG_DATA1   = 3'd4;
    localparam logic [2:0] REG_CTRL    = 3'd5;
    localparam logic [2:0] REG_IEN     = 3'd6;
    localparam logic [2:0] REG_ISR     = 3'd7;

    localparam int DEF_PHI_LOW_CYCLES  = 4;
    localparam int DEF_PHI_HIGH_CYCLES = 4;
    localparam int DEF_MAX_WAIT        = 15;

endpackage

// File: rtl/extbus_master_6502_sync2.sv
// Generic two-flop synchroniser for asynchronous single-bit bus lines;
// the reset value lets pulled-up lines come out of reset in their idle level.
module extbus_master_6502_sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_p0 <= RST_VAL;
            q       <= RST_VAL;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/extbus_master_6502.sv
// 6502-style bus initiator: turns single-beat requests into PHY2-timed bus
// cycles, stretching on RDY low and aborting after MAX_WAIT extra periods.
module extbus_master_6502
    import extbus_pkg::*;
#(
    parameter int PHI_LOW_CYCLES  = DEF_PHI_LOW_CYCLES,
    parameter int PHI_HIGH_CYCLES = DEF_PHI_HIGH_CYCLES,
    parameter int MAX_WAIT        = DEF_MAX_WAIT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_strobe,
    input  logic       req_write,
    input  logic [2:0] req_addr,
    input  logic [7:0] req_wrdata,
    output logic       req_busy,
    output logic       ack,
    output logic       err,
    output logic [7:0] rddata,
    output logic       irq,
    output logic       bus_phy2,
    output logic       bus_cs_n,
    output logic       bus_rw_n,
    output logic [2:0] bus_a,
    output logic [7:0] bus_d_out,
    output logic       bus_d_oe,
    input  logic [7:0] bus_d_in,
    input  logic       bus_rdy,
    input  logic       bus_irq_n
);

    localparam logic [1:0] S_IDLE  = ST_IDLE;
    localparam logic [1:0] S_ARMED = ST_ARMED;
    localparam logic [1:0] S_LOW   = ST_LOW;
    localparam logic [1:0] S_HIGH  = ST_HIGH;

    localparam logic [7:0] LOW_LAST   = 8'(PHI_LOW_CYCLES - 1);
    localparam logic [7:0] HIGH_LAST  = 8'(PHI_HIGH_CYCLES - 1);
    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    logic [7:0] cnt;
    logic       rise;
    logic       fall;
    logic [1:0] state;
    logic       wr_q;
    logic [2:0] addr_q;
    logic [7:0] wrdata_q;
    logic [7:0] wait_cnt;
    logic       rdy_s;
    logic       irq_n_s;

    extbus_master_6502_sync2 #(.RST_VAL(1'b1)) u_sync_rdy (
        .clk   (clk),
        .reset (reset),
        .d     (bus_rdy),
        .q     (rdy_s)
    );

    extbus_master_6502_sync2 #(.RST_VAL(1'b1)) u_sync_irq (
        .clk   (clk),
        .reset (reset),
        .d     (bus_irq_n),
        .q     (irq_n_s)
    );

    assign irq = ~irq_n_s;

    // rise/fall mark the last clk of the low/high phase respectively
    assign rise = ~bus_phy2 && (cnt == LOW_LAST);
    assign fall =  bus_phy2 && (cnt == HIGH_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus_phy2 <= 1'b0;
            cnt      <= 8'd0;
        end else if (rise) begin
            bus_phy2 <= 1'b1;
            cnt      <= 8'd0;
        end else if (fall) begin
            bus_phy2 <= 1'b0;
            cnt      <= 8'd0;
        end else begin
            cnt      <= cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            req_busy  <= 1'b0;
            ack       <= 1'b0;
            err       <= 1'b0;
            rddata    <= 8'd0;
            bus_cs_n  <= 1'b1;
            bus_rw_n  <= 1'b1;
            bus_a     <= 3'd0;
            bus_d_out <= 8'd0;
            bus_d_oe  <= 1'b0;
            wr_q      <= 1'b0;
            addr_q    <= 3'd0;
            wrdata_q  <= 8'd0;
            wait_cnt  <= 8'd0;
        end else begin
            ack <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_strobe && !req_busy) begin
                        wr_q     <= req_write;
                        addr_q   <= req_addr;
                        wrdata_q <= req_wrdata;
                        req_busy <= 1'b1;
                        state    <= S_ARMED;
                    end
                end
                S_ARMED: begin
                    if (fall) begin
                        bus_cs_n <= 1'b0;
                        bus_a    <= addr_q;
                        bus_rw_n <= ~wr_q;
                        wait_cnt <= 8'd0;
                        state    <= S_LOW;
                    end
                end
                S_LOW: begin
                    if (rise) begin
                        state <= S_HIGH;
                        if (wr_q) begin
                            bus_d_oe  <= 1'b1;
                            bus_d_out <= wrdata_q;
                        end
                    end
                end
                S_HIGH: begin
                    if (fall) begin
                        if (rdy_s) begin
                            if (!wr_q)
                                rddata <= bus_d_in;
                            bus_cs_n <= 1'b1;
                            bus_rw_n <= 1'b1;
                            bus_d_oe <= 1'b0;
                            ack      <= 1'b1;
                            err      <= 1'b0;
                            req_busy <= 1'b0;
                            state    <= S_IDLE;
                        end else if (wait_cnt < MAX_WAIT_C) begin
                            // stretch by one full PHY2 period; bus stays driven
                            wait_cnt <= wait_cnt + {7'd0, (wait_cnt != 8'hFF)};
                            state    <= S_LOW;
                        end else begin
                            bus_cs_n <= 1'b1;
                            bus_rw_n <= 1'b1;
                            bus_d_oe <= 1'b0;
                            ack      <= 1'b1;
                            err      <= 1'b1;
                            req_busy <= 1'b0;
                            state    <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
